cpu_clk_ctrl: RTL and testbench

Parametrised CPU clock-enable controller for the DE2-115 MIPS board. It generalises the fixed two-bit clock-control scheme to four run modes: free-run, divided-run, single-step and N-step burst. It adds a debounced step key, a programmable divider and a PC breakpoint. It drives a one-cycle CPU clock enable, not a derived clock, and sits between the board keys/switches and the cpu core.

---
 rtl/cpu_clk_pkg.sv | 18 +
 rtl/cpu_clk_ctrl_key_debounce.sv | 56 +++++
 rtl/cpu_clk_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock-enable controller: run modes and FSM states.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    MODE_FREE  = 2'b00,
    MODE_DIV   = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_STEP  = 2'b10,
    ST_BURST = 2'b11
  } state_e;

endpackage

// File: rtl/cpu_clk_ctrl_key_debounce.sv
// Board key conditioner: 2-FF synchroniser, consecutive-sample debounce and a
// one-cycle press pulse on the debounced 1->0 edge (keys are active-low).
module key_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             press_r;
  logic [CNT_W-1:0] cnt_r;

  // Two-stage synchroniser for the asynchronous raw key; idles released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
    end
  end

  // Any sample agreeing with the accepted level restarts the stability run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_r <= 1'b1;
      cnt_r   <= CNT_ZERO;
      press_r <= 1'b0;
    end else begin
      press_r <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r == CNT_LAST) begin
        cnt_r   <= CNT_ZERO;
        level_r <= sync2_r;
        press_r <= ~sync2_r;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: free-run, divided-run, single-step and N-step
// burst modes with a PC breakpoint; emits a one-cycle advance enable.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_W      = 24,
  parameter int DEB_CYCLES = 16,
  parameter int PC_W       = 8,
  parameter int STEP_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        i_mode,
  input  logic [DIV_W-1:0]  i_div,
  input  logic              i_step_key,
  input  logic [STEP_W-1:0] i_step_count,
  input  logic              i_resume,
  input  logic              i_bp_en,
  input  logic [PC_W-1:0]   i_bp_pc,
  input  logic [PC_W-1:0]   i_pc,
  output logic              o_cpu_en,
  output logic              o_clock,
  output logic              o_halted,
  output logic [1:0]        o_state,
  output logic [STEP_W-1:0] o_steps_left
);

  localparam logic [DIV_W-1:0]  DIV_ZERO  = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  logic              press_s;
  logic              tick_s;
  logic              bp_hit_s;
  logic              en_s;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [DIV_W-1:0]  div_lat_r;
  state_e            state_r;
  state_e            state_nxt_s;
  logic [STEP_W-1:0] steps_r;
  logic [STEP_W-1:0] steps_nxt_s;
  logic              skip_r;
  logic              skip_nxt_s;
  logic              halted_r;
  logic              clock_r;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_key (
    .clk   (clk),
    .reset (reset),
    .key   (i_step_key),
    .press (press_s)
  );

  // Tick generation; a new divide value is only picked up at a wrap.
  always_comb begin
    if (i_mode == MODE_FREE) begin
      tick_s = 1'b1;
    end else begin
      tick_s = (div_cnt_r == div_lat_r);
    end
  end

  // Divide counter runs 0..div_lat_r and reloads the divide value on wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_r <= DIV_ZERO;
      div_lat_r <= DIV_ZERO;
    end else if ((i_mode == MODE_FREE) || (div_cnt_r == div_lat_r)) begin
      div_cnt_r <= DIV_ZERO;
      div_lat_r <= i_div;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

  assign bp_hit_s = i_bp_en & (i_pc == i_bp_pc) & ~skip_r;

  // Next-state and enable decode; skip is consumed by the first enable.
  always_comb begin
    state_nxt_s = state_r;
    steps_nxt_s = steps_r;
    skip_nxt_s  = skip_r;
    en_s        = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (i_mode[1]) begin
          state_nxt_s = ST_HALT;
        end else if (tick_s) begin
          if (bp_hit_s) begin
            state_nxt_s = ST_HALT;
          end else begin
            en_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (!i_mode[1]) begin
          if (i_resume) begin
            state_nxt_s = ST_RUN;
            skip_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_HALT;
          end
        end else if (i_mode == MODE_STEP) begin
          if (press_s) begin
            state_nxt_s = ST_STEP;
          end else begin
            state_nxt_s = ST_HALT;
          end
        end else begin
          if (press_s && (i_step_count != STEP_ZERO)) begin
            state_nxt_s = ST_BURST;
            steps_nxt_s = i_step_count;
            skip_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_HALT;
          end
        end
      end
      ST_STEP: begin
        en_s        = 1'b1;
        state_nxt_s = ST_HALT;
      end
      ST_BURST: begin
        if (i_mode != MODE_BURST) begin
          state_nxt_s = ST_HALT;
        end else if (tick_s) begin
          if (bp_hit_s) begin
            state_nxt_s = ST_HALT;
          end else begin
            en_s        = 1'b1;
            steps_nxt_s = steps_r - STEP_ONE;
            if (steps_r == STEP_ONE) begin
              state_nxt_s = ST_HALT;
            end else begin
              state_nxt_s = ST_BURST;
            end
          end
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
      default: begin
        state_nxt_s = ST_HALT;
      end
    endcase
    if (en_s) begin
      skip_nxt_s = 1'b0;
    end else begin
      skip_nxt_s = skip_nxt_s;
    end
  end

  // State register; the reset state depends on whether the mode is manual.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= i_mode[1] ? ST_HALT : ST_RUN;
      halted_r <= i_mode[1];
      steps_r  <= STEP_ZERO;
      skip_r   <= 1'b0;
      clock_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      halted_r <= (state_nxt_s == ST_HALT);
      steps_r  <= steps_nxt_s;
      skip_r   <= skip_nxt_s;
      clock_r  <= clock_r ^ en_s;
    end
  end

  // Gated by reset so an asserted reset suppresses the enable immediately.
  assign o_cpu_en     = en_s & reset;
  assign o_clock      = clock_r;
  assign o_halted     = halted_r;
  assign o_state      = state_r;
  assign o_steps_left = steps_r;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_cpu_clk_ctrl;

  localparam int DIV_W  = 24;
  localparam int DEB    = 16;
  localparam int PC_W   = 8;
  localparam int STEP_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        i_mode;
  logic [DIV_W-1:0]  i_div;
  logic              i_step_key;
  logic [STEP_W-1:0] i_step_count;
  logic              i_resume;
  logic              i_bp_en;
  logic [PC_W-1:0]   i_bp_pc;
  logic [PC_W-1:0]   i_pc;
  logic              o_cpu_en;
  logic              o_clock;
  logic              o_halted;
  logic [1:0]        o_state;
  logic [STEP_W-1:0] o_steps_left;

  cpu_clk_ctrl #(.DIV_W(DIV_W), .DEB_CYCLES(DEB), .PC_W(PC_W), .STEP_W(STEP_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_mode       (i_mode),
    .i_div        (i_div),
    .i_step_key   (i_step_key),
    .i_step_count (i_step_count),
    .i_resume     (i_resume),
    .i_bp_en      (i_bp_en),
    .i_bp_pc      (i_bp_pc),
    .i_pc         (i_pc),
    .o_cpu_en     (o_cpu_en),
    .o_clock      (o_clock),
    .o_halted     (o_halted),
    .o_state      (o_state),
    .o_steps_left (o_steps_left)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int en_total = 0;

  task automatic chk(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural model: what the controller is doing, not how it is encoded.
  bit m_halt, m_step, m_burst, m_skip, m_clock, m_level, m_press;
  int m_left, m_cnt, m_divl;
  bit n_halt, n_step, n_burst, n_skip, n_clock, n_level, n_press, n_key, n_valid;
  int n_left, n_cnt, n_divl;
  bit q[$];

  always @(negedge clk) begin
    bit en, tick, bp, all_opp;
    int exp_state;
    en = 1'b0;
    if (!reset) begin
      m_halt = i_mode[1]; m_step = 0; m_burst = 0; m_skip = 0; m_clock = 0;
      m_left = 0; m_cnt = 0; m_divl = 0; m_level = 1; m_press = 0;
      q.delete();
      for (int i = 0; i < DEB + 2; i++) q.push_back(1'b1);
      n_valid = 0;
    end else begin
      tick = (i_mode == 2'd0) || (m_cnt == m_divl);
      bp = i_bp_en && (i_pc == i_bp_pc) && !m_skip;
      n_halt = m_halt; n_step = m_step; n_burst = m_burst; n_skip = m_skip;
      n_clock = m_clock; n_left = m_left;
      if (m_step) begin
        en = 1; n_step = 0; n_halt = 1;
      end else if (m_burst) begin
        if (i_mode != 2'd3) begin
          n_burst = 0; n_halt = 1;
        end else if (tick && !bp) begin
          en = 1; n_left = m_left - 1;
          if (n_left == 0) begin n_burst = 0; n_halt = 1; end
        end else if (tick) begin
          n_burst = 0; n_halt = 1;
        end
      end else if (m_halt) begin
        if (i_mode < 2'd2 && i_resume) begin
          n_halt = 0; n_skip = 1;
        end else if (i_mode == 2'd2 && m_press) begin
          n_halt = 0; n_step = 1;
        end else if (i_mode == 2'd3 && m_press && i_step_count != 0) begin
          n_halt = 0; n_burst = 1; n_left = int'(i_step_count); n_skip = 1;
        end
      end else begin
        if (i_mode >= 2'd2) n_halt = 1;
        else if (tick && !bp) en = 1;
        else if (tick) n_halt = 1;
      end
      if (en) begin n_clock = !m_clock; n_skip = 0; end
      if (i_mode == 2'd0 || m_cnt == m_divl) begin
        n_cnt = 0; n_divl = int'(i_div);
      end else begin
        n_cnt = m_cnt + 1; n_divl = m_divl;
      end
      // level flips once the last DEB synchronised samples all disagree with it
      all_opp = 1;
      for (int k = 1; k <= DEB; k++) if (q[q.size() - 1 - k] == m_level) all_opp = 0;
      n_level = all_opp ? !m_level : m_level;
      n_press = all_opp && m_level;
      n_key = i_step_key;
      n_valid = 1;
    end
    exp_state = m_step ? 2 : (m_burst ? 3 : (m_halt ? 1 : 0));
    chk("cpu_en", int'(o_cpu_en), int'(en));
    chk("state", int'(o_state), exp_state);
    chk("halted", int'(o_halted), int'(exp_state == 1));
    chk("steps_left", int'(o_steps_left), m_left);
    chk("clock", int'(o_clock), int'(m_clock));
    if (o_cpu_en) en_total++;
  end

  always @(posedge clk) begin
    if (reset && n_valid) begin
      m_halt = n_halt; m_step = n_step; m_burst = n_burst; m_skip = n_skip;
      m_clock = n_clock; m_left = n_left; m_cnt = n_cnt; m_divl = n_divl;
      m_level = n_level; m_press = n_press;
      q.push_back(n_key);
      void'(q.pop_front());
      n_valid = 0;
    end
  end

  initial begin
    int e0, lat, hold;
    bit found;
    reset = 1'b0; i_mode = 2'd0; i_div = '0; i_step_key = 1'b1; i_step_count = '0;
    i_resume = 1'b0; i_bp_en = 1'b0; i_bp_pc = '0; i_pc = '0;
    cyc(3);
    reset = 1'b1;

    // free run: enable every cycle
    e0 = en_total; cyc(10);
    chk("free_en_count", en_total - e0, 10);
    chk("free_halted", int'(o_halted), 0);

    // divided run, i_div=3: one enable in four
    i_mode = 2'd1; i_div = 24'd3;
    e0 = en_total; cyc(12);
    chk("div3_en_count", en_total - e0, 3);

    // single step: stable press, then a short glitch
    i_mode = 2'd2; cyc(3);
    chk("step_halted", int'(o_halted), 1);
    e0 = en_total; lat = -1;
    i_step_key = 1'b0;
    for (int k = 1; k <= DEB + 5; k++) begin
      @(negedge clk);
      if (o_cpu_en && lat < 0) lat = k - 1;
    end
    @(posedge clk); #1;
    i_step_key = 1'b1;
    cyc(4);
    chk("step_latency", lat, DEB + 3);
    chk("step_en_count", en_total - e0, 1);
    cyc(DEB + 6);
    e0 = en_total;
    i_step_key = 1'b0; cyc(5); i_step_key = 1'b1;
    cyc(DEB + 10);
    chk("glitch_en_count", en_total - e0, 0);

    // burst of 5 at full rate
    i_mode = 2'd3; i_div = '0; i_step_count = 16'd5;
    e0 = en_total;
    i_step_key = 1'b0; cyc(DEB + 6); i_step_key = 1'b1; cyc(6);
    chk("burst5_en_count", en_total - e0, 5);
    chk("burst5_left", int'(o_steps_left), 0);
    chk("burst5_state", int'(o_state), 1);

    // long burst with a second press landing mid-burst
    cyc(DEB + 4);
    i_step_count = 16'd100; e0 = en_total;
    i_step_key = 1'b0; cyc(DEB + 4); i_step_key = 1'b1; cyc(DEB + 4);
    i_step_key = 1'b0; cyc(DEB + 4); i_step_key = 1'b1; cyc(120);
    chk("burst100_en_count", en_total - e0, 100);
    chk("burst100_halted", int'(o_halted), 1);

    // reset while three steps remain
    cyc(DEB + 4);
    i_step_count = 16'd10;
    i_step_key = 1'b0; cyc(DEB + 4); i_step_key = 1'b1;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (o_steps_left == 16'd3) found = 1;
      else cyc(1);
    end
    chk("reach_steps3", int'(found), 1);
    reset = 1'b0; #1;
    chk("rst_cpu_en", int'(o_cpu_en), 0);
    chk("rst_steps_left", int'(o_steps_left), 0);
    cyc(2); reset = 1'b1; cyc(1);
    chk("rst_state_halt", int'(o_state), 1);

    // breakpoint at 0x10, then resume past it
    i_mode = 2'd0; i_bp_en = 1'b1; i_bp_pc = 8'h10; i_pc = 8'h0E;
    i_resume = 1'b1; cyc(1); i_resume = 1'b0;
    e0 = en_total;
    cyc(1); i_pc = 8'h0F; cyc(1); i_pc = 8'h10; cyc(1);
    chk("bp_en_before", en_total - e0, 2);
    chk("bp_halted", int'(o_halted), 1);
    cyc(3);
    chk("bp_still_halted", int'(o_halted), 1);
    e0 = en_total;
    i_resume = 1'b1; cyc(1); i_resume = 1'b0; cyc(1);
    chk("bp_skip_en", en_total - e0, 1);
    i_pc = 8'h11; cyc(3);
    chk("bp_run_after", en_total - e0, 4);
    chk("bp_run_halted", int'(o_halted), 0);

    // randomized traffic, checked cycle by cycle by the model
    hold = 5;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) i_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) i_div = DIV_W'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) i_step_count = STEP_W'($urandom_range(0, 6));
      if (hold == 0) begin
        i_step_key = ~i_step_key;
        hold = int'($urandom_range(1, 40));
      end else begin
        hold--;
      end
      i_resume = ($urandom_range(0, 19) == 0);
      i_bp_en  = 1'($urandom_range(0, 1));
      i_bp_pc  = PC_W'($urandom_range(0, 7));
      i_pc     = PC_W'($urandom_range(0, 7));
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b0; cyc(2); reset = 1'b1;
      end
      cyc(1);
    end

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
